// File: rtl/fabric_pkg.sv
// Shared definitions for the fabric tag-protocol blocks.
// Holds the skid-buffer occupancy states and the cfg_data field layout.
package fabric_pkg;

    // Occupancy of the 2-entry skid buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } del_tag_state_e;

    // cfg_data layout: [tag_width] = chk_en, [tag_width-1:0] = exp_tag
    localparam int unsigned CFG_EXP_TAG_LSB = 0;

    function automatic int unsigned cfg_chk_en_bit(input int unsigned tag_width);
        return tag_width;
    endfunction

endpackage

// File: rtl/fabric_skid_buf2.sv
// Generic 2-entry valid/ready skid buffer.
// in_ready is a register, so no combinational path runs from out_ready to in_ready.
module fabric_skid_buf2
    import fabric_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    del_tag_state_e   state;
    del_tag_state_e   state_n;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             rdy_q;
    logic             push;
    logic             pop;

    assign push      = in_valid && rdy_q;
    assign pop       = out_valid && out_ready;
    assign out_valid = (state != EMPTY);
    assign in_ready  = rdy_q;
    assign out_data  = head_q;

    // Next occupancy from push/pop
    always_comb begin
        state_n = state;
        unique case (state)
            EMPTY: if (push) state_n = ONE;
            ONE: begin
                if (push && !pop)      state_n = FULL;
                else if (!push && pop) state_n = EMPTY;
            end
            FULL:  if (pop) state_n = ONE;
            default: state_n = EMPTY;
        endcase
    end

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_n;
    end

    // Registered ready: held low in reset, then tracks "not FULL"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= (state_n != FULL);
    end

    // Entry storage: head is the output beat, tail holds the second beat when FULL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            unique case (state)
                EMPTY: if (push) head_q <= in_data;
                ONE: begin
                    if (push && pop) head_q <= in_data;
                    else if (push)   tail_q <= in_data;
                end
                FULL:  if (pop) head_q <= tail_q;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fabric_del_tag.sv
// Tag-strip endpoint: takes {tag, data} beats, optionally checks the tag,
// drops mismatching beats and buffers the rest in a 2-entry skid buffer.
// Optional mismatch counter: define FABRIC_DEL_TAG_ERR_CNT_EN.
module fabric_del_tag
    import fabric_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned TAG_WIDTH     = 4,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_WIDTH+TAG_WIDTH-1:0]        in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [(DATA_WIDTH > 0 ? DATA_WIDTH : 1)-1:0] out_data,
    output logic [TAG_WIDTH-1:0]                   out_tag,
    input  logic [TAG_WIDTH:0]                     cfg_data,
    input  logic                                   err_clr,
    output logic                                   err_mismatch
`ifdef FABRIC_DEL_TAG_ERR_CNT_EN
    ,
    output logic [ERR_CNT_WIDTH-1:0]               err_cnt
`endif
);

    localparam int unsigned IN_PW        = DATA_WIDTH + TAG_WIDTH;
    localparam int unsigned OUT_PW       = (DATA_WIDTH > 0) ? DATA_WIDTH : 1;
    localparam int unsigned CONFIG_WIDTH = TAG_WIDTH + 1;
    localparam int unsigned CHK_BIT      = cfg_chk_en_bit(TAG_WIDTH);

    if (TAG_WIDTH < 1) begin : g_bad_tag_width
        $fatal(1, "COMP_DEL_TAG_TAG_WIDTH");
    end
    if (ERR_CNT_WIDTH < 1) begin : g_bad_err_cnt_width
        $fatal(1, "COMP_DEL_TAG_ERR_CNT_WIDTH");
    end
    if (CONFIG_WIDTH != TAG_WIDTH + 1) begin : g_bad_cfg_width
        $fatal(1, "COMP_DEL_TAG_CONFIG_WIDTH");
    end

    logic [TAG_WIDTH-1:0] in_tag;
    logic [TAG_WIDTH-1:0] exp_tag;
    logic                 chk_en;
    logic                 accept;
    logic                 mismatch;
    logic                 buf_in_valid;
    logic [IN_PW-1:0]     head;

    assign in_tag   = in_data[IN_PW-1 -: TAG_WIDTH];
    assign exp_tag  = cfg_data[CFG_EXP_TAG_LSB +: TAG_WIDTH];
    assign chk_en   = cfg_data[CHK_BIT];
    assign accept   = in_valid && in_ready;
    assign mismatch = accept && chk_en && (in_tag != exp_tag);

    // A mismatching beat is still consumed (in_ready unaffected) but never offered
    // to the buffer, so the buffer's own push equals accept && !mismatch.
    assign buf_in_valid = in_valid && !(chk_en && (in_tag != exp_tag));

    fabric_skid_buf2 #(
        .WIDTH (IN_PW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (buf_in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_tag = head[IN_PW-1 -: TAG_WIDTH];

    if (DATA_WIDTH > 0) begin : g_payload
        assign out_data = head[OUT_PW-1:0];
    end else begin : g_no_payload
        assign out_data = '0;
    end

    // Sticky mismatch flag; a new mismatch wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        err_mismatch <= 1'b0;
        else if (mismatch) err_mismatch <= 1'b1;
        else if (err_clr)  err_mismatch <= 1'b0;
    end

`ifdef FABRIC_DEL_TAG_ERR_CNT_EN
    // Saturating mismatch counter; clear with a same-cycle mismatch yields 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= mismatch ? ERR_CNT_WIDTH'(1) : '0;
        end else if (mismatch && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fabric_del_tag.sv
// Directed self-checking bench for fabric_del_tag (DATA_WIDTH=32, TAG_WIDTH=4).
// Table rows are driven on the falling edge and checked on the next falling edge.
module tb_fabric_del_tag;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_tag;
    logic [4:0]  cfg_data;
    logic        err_clr;
    logic        err_mismatch;
`ifdef FABRIC_DEL_TAG_ERR_CNT_EN
    logic [1:0]  err_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fabric_del_tag #(
        .DATA_WIDTH    (32),
        .TAG_WIDTH     (4),
        .ERR_CNT_WIDTH (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_tag      (out_tag),
        .cfg_data     (cfg_data),
        .err_clr      (err_clr),
        .err_mismatch (err_mismatch)
`ifdef FABRIC_DEL_TAG_ERR_CNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    typedef struct {
        logic        iv;
        logic [3:0]  tag;
        logic [31:0] dat;
        logic        ordy;
        logic        clr;
        logic        chk;
        logic [3:0]  etag;
        logic        e_ov;
        logic [31:0] e_od;
        logic [3:0]  e_ot;
        logic        e_ir;
        logic        e_err;
        logic [1:0]  e_cnt;
    } vec_t;

    localparam int NV = 19;
    vec_t vec [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = '0;
        err_clr   = 1'b0;
    endtask

    initial begin
        //          iv tag dat        ordy clr chk etag | ov od          ot   ir err cnt
        // pass-through, chk_en=0
        vec[0]  = '{1, 3, 32'h11, 1, 0, 0, 0,   1, 32'h11, 3, 1, 0, 0};
        vec[1]  = '{1, 3, 32'h12, 1, 0, 0, 0,   1, 32'h12, 3, 1, 0, 0};
        vec[2]  = '{1, 3, 32'h13, 1, 0, 0, 0,   1, 32'h13, 3, 1, 0, 0};
        vec[3]  = '{1, 3, 32'h14, 1, 0, 0, 0,   1, 32'h14, 3, 1, 0, 0};
        vec[4]  = '{0, 0, 32'h00, 1, 0, 0, 0,   0, 32'h00, 0, 1, 0, 0};
        // backpressure: two accepted, third stalls until drained
        vec[5]  = '{1, 3, 32'h11, 0, 0, 0, 0,   1, 32'h11, 3, 1, 0, 0};
        vec[6]  = '{1, 3, 32'h12, 0, 0, 0, 0,   1, 32'h11, 3, 0, 0, 0};
        vec[7]  = '{1, 3, 32'h13, 0, 0, 0, 0,   1, 32'h11, 3, 0, 0, 0};
        vec[8]  = '{1, 3, 32'h13, 1, 0, 0, 0,   1, 32'h12, 3, 1, 0, 0};
        vec[9]  = '{1, 3, 32'h13, 1, 0, 0, 0,   1, 32'h13, 3, 1, 0, 0};
        vec[10] = '{0, 0, 32'h00, 1, 0, 0, 0,   0, 32'h00, 0, 1, 0, 0};
        // mismatch drop, chk_en=1 exp_tag=5
        vec[11] = '{1, 5, 32'hAA, 1, 0, 1, 5,   1, 32'hAA, 5, 1, 0, 0};
        vec[12] = '{1, 2, 32'hBB, 1, 0, 1, 5,   0, 32'h00, 0, 1, 1, 1};
        vec[13] = '{1, 5, 32'hCC, 1, 0, 1, 5,   1, 32'hCC, 5, 1, 1, 1};
        vec[14] = '{0, 0, 32'h00, 1, 1, 1, 5,   0, 32'h00, 0, 1, 0, 0};
        // clear/set race: set wins
        vec[15] = '{1, 2, 32'hDD, 1, 1, 1, 5,   0, 32'h00, 0, 1, 1, 1};
        vec[16] = '{0, 0, 32'h00, 1, 0, 1, 5,   0, 32'h00, 0, 1, 1, 1};
        // chk_en=0 stores any tag and exposes it
        vec[17] = '{1, 2, 32'hEE, 1, 1, 0, 5,   1, 32'hEE, 2, 1, 0, 0};
        vec[18] = '{0, 0, 32'h00, 1, 0, 0, 5,   0, 32'h00, 0, 1, 0, 0};

        // reset state
        rst_n     = 1'b0;
        out_ready = 1'b0;
        cfg_data  = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),     32'd0);
        check("rst_out_valid", 32'(out_valid),    32'd0);
        check("rst_out_data",  out_data,          32'd0);
        check("rst_out_tag",   32'(out_tag),      32'd0);
        check("rst_err",       32'(err_mismatch), 32'd0);
`ifdef FABRIC_DEL_TAG_ERR_CNT_EN
        check("rst_err_cnt",   32'(err_cnt),      32'd0);
`endif
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // table
        for (int i = 0; i < NV; i++) begin
            in_valid  = vec[i].iv;
            in_data   = {vec[i].tag, vec[i].dat};
            out_ready = vec[i].ordy;
            err_clr   = vec[i].clr;
            cfg_data  = {vec[i].chk, vec[i].etag};
            step();
            check($sformatf("r%0d_out_valid", i), 32'(out_valid), 32'(vec[i].e_ov));
            if (vec[i].e_ov) begin
                check($sformatf("r%0d_out_data", i), out_data, vec[i].e_od);
                check($sformatf("r%0d_out_tag", i), 32'(out_tag), 32'(vec[i].e_ot));
            end
            check($sformatf("r%0d_in_ready", i), 32'(in_ready), 32'(vec[i].e_ir));
            check($sformatf("r%0d_err", i), 32'(err_mismatch), 32'(vec[i].e_err));
`ifdef FABRIC_DEL_TAG_ERR_CNT_EN
            check($sformatf("r%0d_err_cnt", i), 32'(err_cnt), 32'(vec[i].e_cnt));
`endif
        end
        idle_inputs();

        // mid-traffic reset with FULL occupancy
        cfg_data  = '0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = {4'd1, 32'h31};
        step();
        in_data   = {4'd1, 32'h32};
        step();
        idle_inputs();
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_out_data",  out_data,       32'h31);
        check("full_in_ready",  32'(in_ready),  32'd0);
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_in_ready",  32'(in_ready),  32'd0);
        check("async_out_data",  out_data,       32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("no_stale_%0d", c), 32'(out_valid), 32'd0);
        end
        check("rerst_in_ready", 32'(in_ready), 32'd1);

        // saturation: five mismatches into a 2-bit counter
        cfg_data = {1'b1, 4'd5};
        in_valid = 1'b1;
        in_data  = {4'd1, 32'h55};
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("sat_drop_%0d", c), 32'(out_valid), 32'd0);
        end
        idle_inputs();
        step();
        check("sat_err", 32'(err_mismatch), 32'd1);
`ifdef FABRIC_DEL_TAG_ERR_CNT_EN
        check("sat_err_cnt", 32'(err_cnt), 32'd3);
`endif
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_err", 32'(err_mismatch), 32'd0);
`ifdef FABRIC_DEL_TAG_ERR_CNT_EN
        check("clr_err_cnt", 32'(err_cnt), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
